// File: rtl/vga_pat_sched_pkg.sv
// Shared VGA test-pattern constants: pattern codes, raster defaults, RGB565 palette.
// latency: n/a (constants only)
// backpressure: n/a
package vga_pat_sched_pkg;

    localparam logic [9:0] H_VALID_DEF = 10'd640;
    localparam logic [9:0] V_VALID_DEF = 10'd480;

    localparam logic [1:0] PAT_COLOR_BAR = 2'd0;
    localparam logic [1:0] PAT_HBARS     = 2'd1;
    localparam logic [1:0] PAT_CHECKER   = 2'd2;
    localparam logic [1:0] PAT_SOLID     = 2'd3;

    typedef logic [15:0] rgb565_t;

    localparam rgb565_t PAL_RED     = 16'hF800;
    localparam rgb565_t PAL_ORANGE  = 16'hFC00;
    localparam rgb565_t PAL_YELLOW  = 16'hFFE0;
    localparam rgb565_t PAL_GREEN   = 16'h07E0;
    localparam rgb565_t PAL_CYAN    = 16'h07FF;
    localparam rgb565_t PAL_BLUE    = 16'h001F;
    localparam rgb565_t PAL_MAGENTA = 16'hF81F;
    localparam rgb565_t PAL_BLACK   = 16'h0000;
    localparam rgb565_t PAL_WHITE   = 16'hFFFF;
    localparam rgb565_t PAL_GREY    = 16'hD69A;

    localparam logic [3:0] PAL_LAST = 4'd9;

    function automatic rgb565_t pal_color(input logic [3:0] idx);
        case (idx)
            4'd0:    pal_color = PAL_RED;
            4'd1:    pal_color = PAL_ORANGE;
            4'd2:    pal_color = PAL_YELLOW;
            4'd3:    pal_color = PAL_GREEN;
            4'd4:    pal_color = PAL_CYAN;
            4'd5:    pal_color = PAL_BLUE;
            4'd6:    pal_color = PAL_MAGENTA;
            4'd7:    pal_color = PAL_BLACK;
            4'd8:    pal_color = PAL_WHITE;
            4'd9:    pal_color = PAL_GREY;
            default: pal_color = PAL_RED;
        endcase
    endfunction

endpackage

// File: rtl/vga_pat_sched_if.sv
// Raster position, key pulses and pattern-select outputs between the timing/key logic and the scheduler.
// latency: n/a (wiring only)
// backpressure: none; all signals are sampled or driven every cycle
interface vga_pat_sched_if;

    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        key_next;
    logic        key_pause;
    logic [1:0]  pat_sel;
    logic [15:0] solid_color;
    logic        frame_start;
    logic        paused;

    modport master (
        output pix_x, pix_y, key_next, key_pause,
        input  pat_sel, solid_color, frame_start, paused
    );

    modport slave (
        input  pix_x, pix_y, key_next, key_pause,
        output pat_sel, solid_color, frame_start, paused
    );

endinterface

// File: rtl/vga_fb_detect.sv
// Frame boundary detector: one-cycle pulse on the first cycle the raster sits at pixel (0,0).
// latency: combinational pulse, same cycle as the (0,0) pixel
// backpressure: none
module vga_fb_detect
    import vga_pat_sched_pkg::*;
#(
    parameter logic [9:0] H_VALID = H_VALID_DEF,
    parameter logic [9:0] V_VALID = V_VALID_DEF
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       fb
);

    logic at_origin;
    logic at_origin_q;

    // Blanking reports 10'h3ff, which the active-area bound rejects.
    assign at_origin = (pix_x == 10'd0) && (pix_y == 10'd0) &&
                       (pix_x < H_VALID) && (pix_y < V_VALID);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            at_origin_q <= 1'b0;
        end else begin
            at_origin_q <= at_origin;
        end
    end

    assign fb = at_origin & ~at_origin_q;

endmodule

// File: rtl/vga_pat_sched.sv
// Test-pattern scheduler: cycles pat_sel/solid_color on frame boundaries, auto or by key.
// latency: outputs update one cycle after the frame-boundary pixel
// backpressure: none; key pulses are latched, never dropped or queued beyond one
module vga_pat_sched
    import vga_pat_sched_pkg::*;
#(
    parameter logic [9:0] H_VALID     = H_VALID_DEF,
    parameter logic [9:0] V_VALID     = V_VALID_DEF,
    parameter logic [7:0] HOLD_FRAMES = 8'd60
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    vga_pat_sched_if.slave bus
);

    localparam logic [1:0] ST_WAIT_SYNC = 2'd0;
    localparam logic [1:0] ST_RUN       = 2'd1;
    localparam logic [1:0] ST_HOLD      = 2'd2;

    logic [1:0] state, state_d;
    logic [7:0] hold_cnt, hold_cnt_d;
    logic       next_pend, next_pend_d;
    logic [3:0] pal_idx, pal_idx_d;
    logic [1:0] pat_q, pat_d;
    rgb565_t    solid_q;
    logic       frame_start_q;
    logic       paused_q;
    logic       fb;
    logic       synced;
    logic       expire;
    logic       advance;

    vga_fb_detect #(
        .H_VALID (H_VALID),
        .V_VALID (V_VALID)
    ) u_fb_detect (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pix_x     (bus.pix_x),
        .pix_y     (bus.pix_y),
        .fb        (fb)
    );

    assign synced = (state != ST_WAIT_SYNC);
    assign expire = (state == ST_RUN) && (hold_cnt == HOLD_FRAMES - 8'd1);

    always_comb begin
        state_d    = state;
        hold_cnt_d = hold_cnt;
        advance    = 1'b0;

        // First boundary only aligns to the raster; advancing starts from the next one.
        if (fb) begin
            if (!synced) begin
                state_d    = ST_RUN;
                hold_cnt_d = 8'd0;
            end else if (next_pend || expire) begin
                advance    = 1'b1;
                hold_cnt_d = 8'd0;
            end else if (state == ST_RUN) begin
                hold_cnt_d = hold_cnt + 8'd1;
            end
        end

        if (bus.key_pause) begin
            if (state == ST_RUN) begin
                state_d = ST_HOLD;
            end else if (state == ST_HOLD) begin
                state_d    = ST_RUN;
                hold_cnt_d = 8'd0;
            end
        end

        // A key on the boundary cycle re-arms the flag for the following boundary.
        next_pend_d = bus.key_next | (next_pend & ~(fb & synced));

        pat_d     = advance ? pat_q + 2'd1 : pat_q;
        pal_idx_d = pal_idx;
        if (advance && (pat_q == PAT_SOLID)) begin
            pal_idx_d = (pal_idx == PAL_LAST) ? 4'd0 : pal_idx + 4'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= ST_WAIT_SYNC;
            hold_cnt      <= 8'd0;
            next_pend     <= 1'b0;
            pal_idx       <= 4'd0;
            pat_q         <= PAT_COLOR_BAR;
            solid_q       <= PAL_RED;
            frame_start_q <= 1'b0;
            paused_q      <= 1'b0;
        end else begin
            state         <= state_d;
            hold_cnt      <= hold_cnt_d;
            next_pend     <= next_pend_d;
            pal_idx       <= pal_idx_d;
            pat_q         <= pat_d;
            solid_q       <= pal_color(pal_idx_d);
            frame_start_q <= fb;
            paused_q      <= (state_d == ST_HOLD);
        end
    end

    assign bus.pat_sel     = pat_q;
    assign bus.solid_color = solid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.paused      = paused_q;

endmodule

// File: tb/tb_vga_pat_sched.sv
// Bench for vga_pat_sched on a shrunken 8x4 raster with HOLD_FRAMES=3.
// Reference model counts advances; pattern and colour follow from that count.
module tb_vga_pat_sched;

    localparam logic [9:0] HV   = 10'd8;
    localparam logic [9:0] VV   = 10'd4;
    localparam int         HOLD = 3;
    localparam logic [9:0] BLK  = 10'h3ff;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    vga_pat_sched_if bus();

    vga_pat_sched #(
        .H_VALID     (HV),
        .V_VALID     (VV),
        .HOLD_FRAMES (8'd3)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [15:0] pal [10] = '{16'hF800, 16'hFC00, 16'hFFE0, 16'h07E0, 16'h07FF,
                              16'h001F, 16'hF81F, 16'h0000, 16'hFFFF, 16'hD69A};

    // Reference model state
    bit m_synced, m_paused, m_pend, m_prev, m_fs;
    int m_cnt, m_adv;
    int fs_count;

    task automatic model_reset();
        m_synced = 0; m_paused = 0; m_pend = 0; m_prev = 0; m_fs = 0;
        m_cnt = 0; m_adv = 0;
    endtask

    task automatic model_step(input logic [9:0] x, input logic [9:0] y, input bit kn, input bit kp);
        bit at0, fbv, was_synced, expire;
        at0 = (x == 10'd0) && (y == 10'd0);
        fbv = at0 && !m_prev;
        m_prev = at0;
        was_synced = m_synced;
        if (fbv) begin
            if (!was_synced) begin
                m_synced = 1;
                m_cnt = 0;
            end else begin
                expire = !m_paused && (m_cnt == HOLD - 1);
                if (m_pend || expire) begin
                    m_adv++;
                    m_cnt = 0;
                    m_pend = 0;
                end else if (!m_paused) begin
                    m_cnt++;
                end
            end
        end
        if (kn) m_pend = 1;
        if (kp && was_synced) begin
            if (m_paused) begin
                m_paused = 0;
                m_cnt = 0;
            end else begin
                m_paused = 1;
            end
        end
        m_fs = fbv;
    endtask

    task automatic step(input logic [9:0] x, input logic [9:0] y, input bit kn, input bit kp);
        bus.pix_x     = x;
        bus.pix_y     = y;
        bus.key_next  = kn;
        bus.key_pause = kp;
        model_step(x, y, kn, kp);
        @(posedge sys_clk);
        #1;
        if (bus.frame_start) fs_count++;
        check("pat_sel", 32'(bus.pat_sel), 32'(m_adv % 4));
        check("solid_color", 32'(bus.solid_color), 32'(pal[(m_adv / 4) % 10]));
        check("frame_start", 32'(bus.frame_start), 32'(m_fs));
        check("paused", 32'(bus.paused), 32'(m_paused));
        bus.key_next  = 1'b0;
        bus.key_pause = 1'b0;
    endtask

    // One full raster: 4 lines of 8 active + 2 blank pixels, then 3 blank cycles.
    task automatic frame(input bit kn_fb, input int kn_mid, input bit kp_mid, input bit rnd);
        int c = 0;
        for (int y = 0; y < int'(VV); y++) begin
            for (int x = 0; x < int'(HV) + 2; x++) begin
                bit kn = 0;
                bit kp = 0;
                logic [9:0] xv, yv;
                xv = (x < int'(HV)) ? 10'(x) : BLK;
                yv = (x < int'(HV)) ? 10'(y) : BLK;
                if (c == 0) begin
                    kn = kn_fb;
                end else begin
                    if (c >= 5 && c < 5 + 2 * kn_mid && (c % 2) == 1) kn = 1;
                    if (c == 3) kp = kp_mid;
                    if (rnd) begin
                        kn = ($urandom_range(0, 19) == 0);
                        kp = ($urandom_range(0, 29) == 0);
                    end
                end
                step(xv, yv, kn, kp);
                c++;
            end
        end
        for (int i = 0; i < 3; i++) step(BLK, BLK, 0, 0);
    endtask

    task automatic do_reset(input string tag);
        bus.pix_x     = BLK;
        bus.pix_y     = BLK;
        bus.key_next  = 1'b0;
        bus.key_pause = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, "_pat"}, 32'(bus.pat_sel), 32'd0);
        check({tag, "_solid"}, 32'(bus.solid_color), 32'hF800);
        check({tag, "_fs"}, 32'(bus.frame_start), 32'd0);
        check({tag, "_paused"}, 32'(bus.paused), 32'd0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int passes;
        logic [1:0] prev_pat;

        bus.pix_x     = BLK;
        bus.pix_y     = BLK;
        bus.key_next  = 1'b0;
        bus.key_pause = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        do_reset("rst0");

        // Free-running auto advance
        fs_count = 0;
        repeat (3) frame(0, 0, 0, 0);
        check("auto_fb3", 32'(bus.pat_sel), 32'd0);
        frame(0, 0, 0, 0);
        check("auto_fb4", 32'(bus.pat_sel), 32'd1);
        repeat (3) frame(0, 0, 0, 0);
        check("auto_fb7", 32'(bus.pat_sel), 32'd2);
        check("fs_count", 32'(fs_count), 32'd7);

        // Pause holds the pattern; key_next advances exactly once
        do_reset("rst1");
        frame(0, 0, 1, 0);
        repeat (10) frame(0, 0, 0, 0);
        check("pause_flag", 32'(bus.paused), 32'd1);
        check("pause_pat", 32'(bus.pat_sel), 32'd0);
        frame(0, 1, 0, 0);
        check("pause_next_wait", 32'(bus.pat_sel), 32'd0);
        frame(0, 0, 0, 0);
        check("pause_next_adv", 32'(bus.pat_sel), 32'd1);
        frame(0, 0, 0, 0);
        check("pause_next_once", 32'(bus.pat_sel), 32'd1);

        // Three key_next pulses on an expiry frame merge into one advance
        do_reset("rst2");
        repeat (2) frame(0, 0, 0, 0);
        frame(0, 3, 0, 0);
        frame(0, 0, 0, 0);
        check("merge_adv", 32'(bus.pat_sel), 32'd1);
        repeat (2) frame(0, 0, 0, 0);
        check("merge_no_extra", 32'(bus.pat_sel), 32'd1);
        frame(0, 0, 0, 0);
        check("merge_cnt_clear", 32'(bus.pat_sel), 32'd2);

        // key_next on the boundary cycle, then reset mid-frame at pattern 2
        do_reset("rst3");
        frame(0, 0, 0, 0);
        frame(1, 0, 0, 0);
        check("kfb_not_now", 32'(bus.pat_sel), 32'd0);
        frame(0, 0, 0, 0);
        check("kfb_next", 32'(bus.pat_sel), 32'd1);
        repeat (3) frame(0, 0, 0, 0);
        check("kfb_pat2", 32'(bus.pat_sel), 32'd2);
        step(10'd0, 10'd0, 0, 0);
        step(10'd1, 10'd0, 0, 0);
        step(10'd2, 10'd0, 0, 0);
        do_reset("rst_mid");
        step(BLK, BLK, 1, 0);
        frame(0, 0, 0, 0);
        check("post_rst_fb1", 32'(bus.pat_sel), 32'd0);
        frame(0, 0, 0, 0);
        check("post_rst_fb2", 32'(bus.pat_sel), 32'd1);

        // Palette walk across ten passes through the solid pattern
        do_reset("rst4");
        passes = 0;
        prev_pat = 2'd0;
        for (int i = 0; i < 42; i++) begin
            frame(0, 1, 0, 0);
            if (bus.pat_sel == 2'd3) begin
                passes++;
                if (passes == 1)  check("pal_pass1", 32'(bus.solid_color), 32'hF800);
                if (passes == 2)  check("pal_pass2", 32'(bus.solid_color), 32'hFC00);
                if (passes == 10) check("pal_pass10", 32'(bus.solid_color), 32'hD69A);
            end
            if (prev_pat == 2'd3 && bus.pat_sel == 2'd0 && passes == 10)
                check("pal_wrap", 32'(bus.solid_color), 32'hF800);
            prev_pat = bus.pat_sel;
        end
        check("pal_passes", 32'(passes), 32'd10);

        // Randomized keys against the model
        do_reset("rst5");
        repeat (40) frame(0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_pat_sched.md
VGA_PAT_SCHED -- requirements
Module: vga_pat_sched

Interface
REQ-001 Parameter H_VALID, 10'd640: horizontal active pixels.
REQ-002 Parameter V_VALID, 10'd480: vertical active lines.
REQ-003 Parameter HOLD_FRAMES, 8'd60: frames each pattern is held in auto mode; legal range 1..255.
REQ-004 sys_clk  input  1: pixel clock; the one clock of the block; all logic on the rising edge.
REQ-005 sys_rst_n  input  1: reset, asynchronous, active-low.
REQ-006 pix_x  input  10: current pixel column; 10'h3ff outside the active area.
REQ-007 pix_y  input  10: current pixel line; 10'h3ff outside the active area.
REQ-008 key_next  input  1: single-cycle pulse, already debounced; request to advance the pattern.
REQ-009 key_pause  input  1: single-cycle pulse, already debounced; toggles auto-advance.
REQ-010 pat_sel  output  2: registered pattern select: 0 colour bar, 1 horizontal bars, 2 checkerboard, 3 solid colour.
REQ-011 solid_color  output  16: registered RGB565 colour used when pat_sel==3.
REQ-012 frame_start  output  1: registered one-cycle pulse marking the first active pixel of each frame.
REQ-013 paused  output  1: registered; 1 while auto-advance is suspended.

Function
REQ-014 Frame boundary (fb) is detected when pix_x==0 and pix_y==0 and the previous cycle did not satisfy the same condition; one fb per frame.
REQ-015 frame_start is asserted exactly one cycle after fb, for one cycle.
REQ-016 FSM states: WAIT_SYNC, RUN, HOLD.
- WAIT_SYNC: after reset; on the first fb, go to RUN, hold_cnt=0, outputs unchanged.
- RUN: hold_cnt increments on each fb; on an fb with hold_cnt==HOLD_FRAMES-1, advance and clear hold_cnt.
- HOLD: hold_cnt frozen; no auto-advance.
REQ-017 key_pause in RUN goes to HOLD (paused=1); key_pause in HOLD goes to RUN (paused=0) with hold_cnt cleared; in WAIT_SYNC it is ignored.
REQ-018 key_next sets a sticky next_pend flag in any state; pending requests do not accumulate (max one).
REQ-019 The pattern changes only on an fb; it never changes mid-frame.
REQ-020 On an fb in RUN or HOLD with next_pend=1: advance once, clear next_pend, clear hold_cnt.
REQ-021 Auto-expiry and next_pend on the same fb produce a single advance.
REQ-022 key_next on the same cycle as an fb is honoured at the following fb, not the current one.
REQ-023 Advance: pat_sel = pat_sel+1 modulo 4 (3 wraps to 0).
REQ-024 Leaving pattern 3 steps the palette index 0..9, wrapping 9 to 0. Palette order:
- F800, FC00, FFE0, 07E0, 07FF, 001F, F81F, 0000, FFFF, D69A.
- solid_color is updated in the same cycle as pat_sel.
REQ-025 key_pause and key_next together: both take effect (mode toggle plus pending advance).
REQ-026 pix_x/pix_y values of 10'h3ff never produce an fb.

Reset
REQ-027 Asserting reset: state=WAIT_SYNC, pat_sel=0, palette index=0, solid_color=16'hF800, frame_start=0, paused=0, hold_cnt=0, next_pend=0, fb history cleared.
REQ-028 Reset asserted mid-frame takes effect immediately.
REQ-029 After reset, no advance occurs before the second fb.

Structure
REQ-030 A shared package holds the RGB565 palette constants, the pattern-code constants (0..3) and the H_VALID/V_VALID defaults, for reuse by the pixel generator.
REQ-031 One sub-module, vga_fb_detect, produces the fb pulse from pix_x/pix_y.
- The FSM, counters and palette logic stay in vga_pat_sched.

Verification (HOLD_FRAMES=3, reduced-frame raster stimulus)
REQ-032 Reset, then 7 frames free-running -> pat_sel 0 through fb #3, 1 at fb #4, 2 at fb #7; frame_start pulses once per frame.
REQ-033 Cycle through pattern 3 twice -> solid_color F800 on the first pass, FC00 on the second; index wraps 9 to 0 after ten passes (D69A, then F800).
REQ-034 key_pause in frame 1, then 10 frames -> paused=1, pat_sel held at 0; key_next then gives pat_sel=1 at the next fb only.
REQ-035 key_next pulsed three times in one frame, coinciding with auto-expiry -> exactly one advance; hold_cnt=0.
REQ-036 key_next on the fb cycle -> advance at the following fb; reset mid-frame with pat_sel=2 -> outputs at reset values, next advance at the second fb.
